// File: rtl/riscv_multicycle_ctrl_fsm_if.sv
// Control/status bundle between the multi-cycle controller and the RV32I datapath/memory port.
// The master modport is the controller side; the slave modport is the datapath side.
interface riscv_multicycle_ctrl_fsm_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       addr_src;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] ALUOp;
    logic       func7_mask;
    logic [3:0] state;
    logic       bus_err;
    logic       illegal;

    modport master (
        input  opcode, funct3, zero, mem_ready,
        output mem_req, mem_we, addr_src, ir_write, pc_write, pc_src, reg_write,
               result_src, alu_src_a, alu_src_b, ALUOp, func7_mask, state, bus_err, illegal
    );

    modport slave (
        output opcode, funct3, zero, mem_ready,
        input  mem_req, mem_we, addr_src, ir_write, pc_write, pc_src, reg_write,
               result_src, alu_src_a, alu_src_b, ALUOp, func7_mask, state, bus_err, illegal
    );
endinterface

// File: rtl/riscv_multicycle_ctrl_fsm.sv
// Multi-cycle RV32I main controller: FETCH/DECODE/EXECUTE/MEM/WB sequencing with a memory timeout.
// Optional macro ILLEGAL_TRAP_EN: unknown opcodes trap and set the sticky illegal flag.
module riscv_multicycle_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    riscv_multicycle_ctrl_fsm_if.master   bus
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JAL    = 4'd9,
        S_TRAP   = 4'd10
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_bus_err;
    logic             w_wait;
    logic             w_timeout;
    logic             w_f7m;

    logic             w_mem_req;
    logic             w_mem_we;
    logic             w_addr_src;
    logic             w_ir_write;
    logic             w_pc_write;
    logic             w_pc_src;
    logic             w_reg_write;
    logic [1:0]       w_result_src;
    logic [1:0]       w_alu_src_a;
    logic [1:0]       w_alu_src_b;
    logic [1:0]       w_alu_op;
    logic             w_func7_mask;
`ifdef ILLEGAL_TRAP_EN
    logic             r_illegal;
    logic             w_set_illegal;
`endif

    // Memory handshake: a transfer completes in any cycle where mem_req and mem_ready are both high;
    // mem_req stays asserted (and the state holds) until then, or until the wait limit expires.
    assign w_wait    = w_mem_req & ~bus.mem_ready;
    assign w_timeout = w_wait & (r_cnt == LIMIT);
    // funct3 = 101 is SRLI/SRAI, where IR[30] carries the shift type and must reach the ALU.
    assign w_f7m     = (bus.opcode == OPC_OPIMM) && (bus.funct3 != 3'b101);

    always_comb begin
        w_next       = r_state;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_addr_src   = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_pc_src     = 1'b0;
        w_reg_write  = 1'b0;
        w_result_src = 2'b00;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b00;
        w_alu_op     = 2'b00;
        w_func7_mask = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        w_set_illegal = 1'b0;
`endif
        case (r_state)
            S_FETCH: begin
                w_mem_req   = 1'b1;
                w_alu_src_b = 2'b10;
                w_alu_op    = 2'b10;
                if (bus.mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
                w_alu_op    = 2'b10;
                case (bus.opcode)
                    OPC_LOAD, OPC_STORE: w_next = S_MEMADR;
                    OPC_OP, OPC_OPIMM:   w_next = S_EXEC;
                    OPC_BRANCH:          w_next = S_BRANCH;
                    OPC_JAL:             w_next = S_JAL;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        w_set_illegal = 1'b1;
                        w_next        = S_TRAP;
`else
                        w_next        = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_alu_op    = 2'b10;
                w_next      = (bus.opcode == OPC_STORE) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_mem_req  = 1'b1;
                w_addr_src = 1'b1;
                if (bus.mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                w_result_src = 2'b01;
                w_next       = S_FETCH;
            end
            S_MEMWR: begin
                w_mem_req  = 1'b1;
                w_mem_we   = 1'b1;
                w_addr_src = 1'b1;
                if (bus.mem_ready) w_next = S_FETCH;
            end
            S_EXEC: begin
                w_alu_src_a  = 2'b10;
                w_alu_src_b  = (bus.opcode == OPC_OPIMM) ? 2'b01 : 2'b00;
                w_func7_mask = w_f7m;
                w_next       = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write  = 1'b1;
                w_func7_mask = w_f7m;
                w_next       = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a = 2'b10;
                w_alu_op    = 2'b01;
                w_pc_src    = 1'b1;
                w_pc_write  = ((bus.funct3 == 3'b000) &&  bus.zero) ||
                              ((bus.funct3 == 3'b001) && !bus.zero);
                w_next      = S_FETCH;
            end
            S_JAL: begin
                w_alu_src_a  = 2'b01;
                w_alu_src_b  = 2'b10;
                w_alu_op     = 2'b10;
                w_reg_write  = 1'b1;
                w_result_src = 2'b10;
                w_pc_write   = 1'b1;
                w_pc_src     = 1'b1;
                w_next       = S_FETCH;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
        if (w_timeout) w_next = S_TRAP;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((w_next != r_state) || bus.mem_ready) begin
                r_cnt <= '0;
            end else if (w_wait) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_timeout) r_bus_err <= 1'b1;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegal <= 1'b0;
        end else if (w_set_illegal) begin
            r_illegal <= 1'b1;
        end
    end
    assign bus.illegal = r_illegal;
`else
    assign bus.illegal = 1'b0;
`endif

    assign bus.mem_req    = w_mem_req;
    assign bus.mem_we     = w_mem_we;
    assign bus.addr_src   = w_addr_src;
    assign bus.ir_write   = w_ir_write;
    assign bus.pc_write   = w_pc_write;
    assign bus.pc_src     = w_pc_src;
    assign bus.reg_write  = w_reg_write;
    assign bus.result_src = w_result_src;
    assign bus.alu_src_a  = w_alu_src_a;
    assign bus.alu_src_b  = w_alu_src_b;
    assign bus.ALUOp      = w_alu_op;
    assign bus.func7_mask = w_func7_mask;
    assign bus.state      = r_state;
    assign bus.bus_err    = r_bus_err;

endmodule

// File: tb/tb_riscv_multicycle_ctrl_fsm.sv
// Bench for riscv_multicycle_ctrl_fsm: per-instruction expected cycle traces built from the
// instruction-level behaviour, compared cycle by cycle against every controller output.
module tb_riscv_multicycle_ctrl_fsm;

    localparam int TMO = 4;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err = 0;

    riscv_multicycle_ctrl_fsm_if bus ();

    riscv_multicycle_ctrl_fsm #(.MEM_TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // expected per-cycle output vectors and the inputs to apply in that cycle
    logic [21:0] exp_q[$];
    logic [11:0] in_q[$];
    logic [6:0]  cur_op;
    logic [2:0]  cur_f3;
    logic        cur_z;
    bit          trap_pending;

    function automatic logic [21:0] pk(input logic [3:0] st, input logic req, we, as, irw, pcw, pcs, rw,
                                       input logic [1:0] rs, a, b, op, input logic f7, be, il);
        return {st, req, we, as, irw, pcw, pcs, rw, rs, a, b, op, f7, be, il};
    endfunction

    function automatic logic [21:0] observed();
        return pk(bus.state, bus.mem_req, bus.mem_we, bus.addr_src, bus.ir_write, bus.pc_write,
                  bus.pc_src, bus.reg_write, bus.result_src, bus.alu_src_a, bus.alu_src_b,
                  bus.ALUOp, bus.func7_mask, bus.bus_err, bus.illegal);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [21:0] e, input logic rdy);
        exp_q.push_back(e);
        in_q.push_back({cur_op, cur_f3, cur_z, rdy});
    endtask

    task automatic push_trap(input logic be, input logic il);
        for (int k = 0; k < 3; k++)
            push(pk(4'd10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, be, il), 1'($urandom_range(0, 1)));
        trap_pending = 1;
    endtask

    // d = number of not-ready cycles the memory inserts before answering
    task automatic mem_phase(input logic [3:0] st, input int d, input logic we, input logic as,
                             input logic [1:0] a, input logic [1:0] b, input logic [1:0] op,
                             input logic fetch, output bit ok);
        int n;
        n = (d >= TMO) ? TMO : d;
        for (int k = 0; k < n; k++)
            push(pk(st, 1, we, as, 0, 0, 0, 0, 2'b00, a, b, op, 0, 0, 0), 1'b0);
        if (d >= TMO) begin
            ok = 0;
            push_trap(1'b1, 1'b0);
        end else begin
            ok = 1;
            push(pk(st, 1, we, as, fetch, fetch, 0, 0, 2'b00, a, b, op, 0, 0, 0), 1'b1);
        end
    endtask

    task automatic gen_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                             input int df, input int dm);
        bit ok;
        logic f7;
        logic taken;
        cur_op = op; cur_f3 = f3; cur_z = z;
        mem_phase(4'd0, df, 0, 0, 2'b00, 2'b10, 2'b10, 1'b1, ok);
        if (!ok) return;
        push(pk(4'd1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b10, 0, 0, 0), 1'($urandom_range(0, 1)));
        f7 = (op == OPIMM) && (f3 != 3'b101);
        taken = ((f3 == 3'b000) && z) || ((f3 == 3'b001) && !z);
        case (op)
            LOAD: begin
                push(pk(4'd2, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0, 0, 0), 1'b0);
                mem_phase(4'd3, dm, 0, 1, 2'b00, 2'b00, 2'b00, 1'b0, ok);
                if (ok) push(pk(4'd4, 0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0), 1'b0);
            end
            STORE: begin
                push(pk(4'd2, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0, 0, 0), 1'b0);
                mem_phase(4'd5, dm, 1, 1, 2'b00, 2'b00, 2'b00, 1'b0, ok);
            end
            OP, OPIMM: begin
                push(pk(4'd6, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, (op == OP) ? 2'b00 : 2'b01, 2'b00, f7, 0, 0), 1'b1);
                push(pk(4'd7, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, f7, 0, 0), 1'b1);
            end
            BRANCH: push(pk(4'd8, 0, 0, 0, 0, taken, 1, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0, 0), 1'b1);
            JAL:    push(pk(4'd9, 0, 0, 0, 0, 1, 1, 1, 2'b10, 2'b01, 2'b10, 2'b10, 0, 0, 0), 1'b1);
            default: begin
`ifdef ILLEGAL_TRAP_EN
                push_trap(1'b0, 1'b1);
`endif
            end
        endcase
    endtask

    task automatic run_queue(input string tag);
        logic [11:0] in;
        int cyc;
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            in = in_q.pop_front();
            rst = 1'b0;
            {bus.opcode, bus.funct3, bus.zero, bus.mem_ready} = in;
            #1;
            check($sformatf("%s_c%0d", tag, cyc), 32'(observed()), 32'(exp_q.pop_front()));
            cyc++;
        end
    endtask

    // rst is left high; the next run_queue cycle releases it
    task automatic do_reset(input int pre_state);
        @(negedge clk);
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        if (pre_state >= 0) begin
            check("pre_rst_state", 32'(bus.state), 32'(pre_state));
            check("pre_rst_we", 32'(bus.mem_we), 32'(pre_state == 5));
        end
        @(negedge clk);
        #1;
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_mem_req", 32'(bus.mem_req), 32'd1);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_bus_err", 32'(bus.bus_err), 32'd0);
        check("rst_illegal", 32'(bus.illegal), 32'd0);
        trap_pending = 0;
    endtask

    task automatic do_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                            input logic z, input int df, input int dm);
        gen_instr(op, f3, z, df, dm);
        run_queue(tag);
        if (trap_pending) do_reset(-1);
    endtask

    initial begin
        logic [6:0] op;
        int df;
        int dm;
        bus.opcode = 7'd0; bus.funct3 = 3'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        trap_pending = 0;
        do_reset(-1);

        do_instr("add", OP, 3'b000, 0, 0, 0);
        do_instr("lw_wait3", LOAD, 3'b010, 0, 0, 3);
        do_instr("beq_z1", BRANCH, 3'b000, 1, 0, 0);
        do_instr("beq_z0", BRANCH, 3'b000, 0, 0, 0);
        do_instr("bne_z0", BRANCH, 3'b001, 0, 0, 0);
        do_instr("blt", BRANCH, 3'b100, 1, 0, 0);
        do_instr("addi", OPIMM, 3'b000, 0, 1, 0);
        do_instr("srai", OPIMM, 3'b101, 0, 0, 0);
        do_instr("jal", JAL, 3'b000, 0, 0, 0);
        do_instr("sw", STORE, 3'b010, 0, 0, 2);
        do_instr("fetch_tmo", OP, 3'b000, 0, 100, 0);
        do_instr("edge_tmo", LOAD, 3'b010, 0, TMO - 1, TMO - 1);
        do_instr("memrd_tmo", LOAD, 3'b010, 0, 0, TMO);
        do_instr("unknown", 7'b0000000, 3'b000, 0, 0, 0);

        // reset while a store is being acknowledged must not complete the store
        cur_op = STORE; cur_f3 = 3'b010; cur_z = 0;
        push(pk(4'd0, 1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b10, 2'b10, 0, 0, 0), 1'b1);
        push(pk(4'd1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b10, 0, 0, 0), 1'b0);
        push(pk(4'd2, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0, 0, 0), 1'b0);
        push(pk(4'd5, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0), 1'b0);
        run_queue("sw_rst");
        do_reset(5);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 6))
                0: op = LOAD;
                1: op = STORE;
                2: op = OP;
                3: op = OPIMM;
                4: op = BRANCH;
                5: op = JAL;
                default: op = ($urandom_range(0, 1) == 0) ? SYSTEM : 7'b0000000;
            endcase
            df = ($urandom_range(0, 9) == 0) ? TMO + 1 : $urandom_range(0, TMO - 1);
            dm = ($urandom_range(0, 9) == 0) ? TMO : $urandom_range(0, TMO - 1);
            do_instr($sformatf("rnd%0d", i), op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), df, dm);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
